// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : In-order queue of in-flight 2-bit branch predictions. Retires
//            the oldest entry against the execute outcome, produces the
//            pattern-table counter update, and flushes/redirects fetch on a
//            misprediction.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    output logic              pred_ready,
    input  logic [ADDR_W-1:0] pred_pc,
    input  logic              pred_taken,
    input  logic [1:0]        pred_state,
    input  logic [ADDR_W-1:0] pred_target,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    output logic              upd_valid,
    output logic [IDX_W-1:0]  upd_idx,
    output logic [1:0]        upd_state,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       mispredict_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  c_full     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  c_ptr_one  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(4);
    localparam logic [15:0]       c_miss_max = 16'hFFFF;

    // Counter encoding: strongly taken = 00 ... strongly not-taken = 11
    localparam logic [1:0] c_st  = 2'b00;
    localparam logic [1:0] c_t   = 2'b01;
    localparam logic [1:0] c_nt  = 2'b10;
    localparam logic [1:0] c_snt = 2'b11;

    logic [ADDR_W-1:0] r_pc_mem    [DEPTH];
    logic              r_taken_mem [DEPTH];
    logic [1:0]        r_state_mem [DEPTH];
    logic [ADDR_W-1:0] r_tgt_mem   [DEPTH];

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_upd_valid;
    logic [IDX_W-1:0]  r_upd_idx;
    logic [1:0]        r_upd_state;
    logic              r_flush;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [15:0]       r_mispredict_cnt;

    logic              w_pred_ready;
    logic              w_res_ready;
    logic              w_fire;
    logic              w_push;
    logic              w_mispredict;
    logic [ADDR_W-1:0] w_head_pc;
    logic              w_head_taken;
    logic [1:0]        w_head_state;
    logic [ADDR_W-1:0] w_head_target;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] w_redirect;

    // Handshakes depend only on registered state, never on same-cycle resolution
    assign w_pred_ready = (r_count != c_full) && !r_flush;
    assign w_res_ready  = (r_count != '0);
    assign w_fire       = res_valid && w_res_ready;

    assign w_head_pc     = r_pc_mem[r_rptr];
    assign w_head_taken  = r_taken_mem[r_rptr];
    assign w_head_state  = r_state_mem[r_rptr];
    assign w_head_target = r_tgt_mem[r_rptr];

    // A taken/taken pair still mispredicts if the target was wrong
    assign w_mispredict = w_fire &&
                          ((w_head_taken != res_taken) ||
                           (w_head_taken && res_taken && (w_head_target != res_target)));

    // An allocation racing a mispredict belongs to the wrong path and is dropped
    assign w_push     = pred_valid && w_pred_ready && !w_mispredict;
    assign w_redirect = res_taken ? res_target : (w_head_pc + c_pc_step);

    // Saturating 2-bit counter transition for the retiring entry
    always_comb begin
        w_next_state = c_snt;
        case (w_head_state)
            c_st:       w_next_state = res_taken ? c_st : c_t;
            c_t, c_nt:  w_next_state = res_taken ? c_st : c_snt;
            default:    w_next_state = res_taken ? c_nt : c_snt;
        endcase
    end

    // Entry storage write; contents survive reset, only pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]    <= pred_pc;
            r_taken_mem[r_wptr] <= pred_taken;
            r_state_mem[r_wptr] <= pred_state;
            r_tgt_mem[r_wptr]   <= pred_target;
        end
    end

    // Queue pointers and occupancy; a mispredict discards every entry
    always_ff @(posedge clk) begin
        if (rst || w_mispredict) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_fire) r_rptr <= r_rptr + c_ptr_one;
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered table update, flush/redirect and mispredict statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_valid      <= 1'b0;
            r_upd_idx        <= '0;
            r_upd_state      <= '0;
            r_flush          <= 1'b0;
            r_redirect_pc    <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_upd_valid <= w_fire;
            r_flush     <= w_mispredict;
            if (w_fire) begin
                r_upd_idx   <= w_head_pc[IDX_W+1:2];
                r_upd_state <= w_next_state;
            end
            if (w_mispredict) begin
                r_redirect_pc <= w_redirect;
                if (r_mispredict_cnt != c_miss_max) begin
                    r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
                end
            end
        end
    end

    assign pred_ready     = w_pred_ready;
    assign res_ready      = w_res_ready;
    assign upd_valid      = r_upd_valid;
    assign upd_idx        = r_upd_idx;
    assign upd_state      = r_upd_state;
    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Scoreboard bench for branch_resolve_unit. A reference model
//            queues the expected registered outputs each cycle; scenario
//            tasks pop and compare after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 6;

    logic              clk;
    logic              rst;
    logic              pred_valid;
    logic              pred_ready;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_taken;
    logic [1:0]        pred_state;
    logic [ADDR_W-1:0] pred_target;
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic [1:0]        upd_state;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [15:0]       mispredict_cnt;

    branch_resolve_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_state     (pred_state),
        .pred_target    (pred_target),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_state      (upd_state),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [1:0]  st;
        logic [31:0] tgt;
    } ent_t;

    // {upd_valid, upd_idx, upd_state, flush, redirect_pc, mispredict_cnt}
    logic [57:0] sb[$];
    ent_t        m_q[$];
    logic        m_flush;
    logic [5:0]  m_idx;
    logic [1:0]  m_st;
    logic [31:0] m_redir;
    logic [15:0] m_cnt;

    logic [57:0] obs;
    logic [57:0] exp_v;
    int          errors = 0;
    int          checks = 0;

    assign obs = {upd_valid, upd_idx, upd_state, flush, redirect_pc, mispredict_cnt};

    // Counter transition written from the direction table (ST=00 .. SNT=11)
    function automatic logic [1:0] next_ctr(input logic [1:0] s, input logic t);
        case (s)
            2'b00:   return t ? 2'b00 : 2'b01;
            2'b01:   return t ? 2'b00 : 2'b11;
            2'b10:   return t ? 2'b00 : 2'b11;
            default: return t ? 2'b10 : 2'b11;
        endcase
    endfunction

    // Drive one cycle of stimulus, advance the model, queue expected outputs
    task automatic step(input logic r, input logic pv, input logic [31:0] pc,
                        input logic pt, input logic [1:0] ps, input logic [31:0] ptgt,
                        input logic rv, input logic rt, input logic [31:0] rtgt);
        logic fire_res, fire_pred, mis;
        ent_t h;
        rst = r; pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_state = ps;
        pred_target = ptgt; res_valid = rv; res_taken = rt; res_target = rtgt;
        mis = 1'b0;
        fire_res = 1'b0;
        if (r) begin
            m_q.delete();
            m_flush = 1'b0; m_idx = '0; m_st = '0; m_redir = '0; m_cnt = '0;
        end else begin
            fire_res  = rv && (m_q.size() != 0);
            fire_pred = pv && (m_q.size() != DEPTH) && !m_flush;
            if (fire_res) begin
                h = m_q.pop_front();
                m_idx = h.pc[7:2];
                m_st  = next_ctr(h.st, rt);
                mis   = (h.taken != rt) || (h.taken && rt && (h.tgt != rtgt));
                if (mis) begin
                    m_redir = rt ? rtgt : h.pc + 32'd4;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
            if (mis) m_q.delete();
            else if (fire_pred) m_q.push_back('{pc, pt, ps, ptgt});
            m_flush = mis;
        end
        sb.push_back({fire_res, m_idx, m_st, mis, m_redir, m_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset_out: got %h expected %h", obs, exp_v); end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, exp_v); end
        checks++;
        if ({pred_ready, res_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_ready: got %b expected 10", {pred_ready, res_ready});
        end
    endtask

    task automatic test_correct();
        step(0, 1, 32'h100, 1, 2'b01, 32'h200, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL correct_alloc: got %h expected %h", obs, exp_v); end
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h200);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL correct_resolve: got %h expected %h", obs, exp_v); end
        checks++;
        if ({upd_valid, upd_idx, upd_state, flush} !== {1'b1, 6'h00, 2'b00, 1'b0}) begin
            errors++; $display("FAIL correct_update: got %b/%h/%b/%b expected 1/00/00/0",
                               upd_valid, upd_idx, upd_state, flush);
        end
    endtask

    task automatic test_dir_mispredict();
        step(0, 1, 32'h104, 0, 2'b10, 32'h0,   0, 0, 0);
        step(0, 1, 32'h110, 1, 2'b00, 32'h500, 0, 0, 0);
        step(0, 1, 32'h114, 0, 2'b11, 32'h0,   0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h300);
        for (int i = 0; i < 4; i++) begin
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v && i == 3) begin errors++; $display("FAIL dir_mispredict: got %h expected %h", obs, exp_v); end
        end
        checks++;
        if ({flush, redirect_pc, upd_state, mispredict_cnt, res_ready, pred_ready} !==
            {1'b1, 32'h300, 2'b00, 16'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL dir_flush: got f=%b pc=%h st=%b cnt=%0d rr=%b pr=%b expected 1 300 00 1 0 0",
                               flush, redirect_pc, upd_state, mispredict_cnt, res_ready, pred_ready);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL dir_after: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_target_mispredict();
        step(0, 1, 32'h120, 1, 2'b00, 32'h400, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h404);
        exp_v = sb.pop_front(); exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v || {flush, redirect_pc} !== {1'b1, 32'h404}) begin
            errors++; $display("FAIL target_mispredict: got %h expected %h", obs, exp_v);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h108, 1, 2'b00, 32'h600, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || {flush, redirect_pc, upd_state} !== {1'b1, 32'h10C, 2'b01}) begin
            errors++; $display("FAIL nt_mispredict: got %h expected %h", obs, exp_v);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL target_after: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_full_wrap();
        ent_t h;
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 32'h200 + 32'(4 * i), i[0], i[1:0], 32'h1000 + 32'(i), 0, 0, 0);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL fill_%0d: got %h expected %h", i, obs, exp_v); end
        end
        checks++;
        if ({pred_ready, res_ready} !== 2'b01) begin
            errors++; $display("FAIL full_ready: got %b expected 01", {pred_ready, res_ready});
        end
        // Resolve correctly while allocating; later entries sit across the wrap
        for (int i = 0; i < 4; i++) begin
            h = m_q[0];
            step(0, 1, 32'h240 + 32'(4 * i), 1, 2'b01, 32'h2000 + 32'(i), 1, h.taken, h.tgt);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL wrap_swap_%0d: got %h expected %h", i, obs, exp_v); end
        end
        while (m_q.size() != 0) begin
            h = m_q[0];
            step(0, 0, 0, 0, 0, 0, 1, h.taken, h.tgt);
            exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL wrap_drain: got %h expected %h", obs, exp_v); end
        end
        checks++;
        if ({pred_ready, res_ready} !== 2'b10) begin
            errors++; $display("FAIL drained_ready: got %b expected 10", {pred_ready, res_ready});
        end
    endtask

    task automatic test_empty();
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h999);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v || {upd_valid, flush} !== 2'b00) begin
            errors++; $display("FAIL empty_resolve: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(0, 1, 32'h500 + 32'(4 * i), 0, 2'b10, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) exp_v = sb.pop_front();
        step(1, 1, 32'h600, 1, 2'b00, 32'h700, 1, 1, 32'h800);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v || obs !== 58'd0 || {pred_ready, res_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_mid: got %h rdy=%b expected %h rdy=10",
                               obs, {pred_ready, res_ready}, exp_v);
        end
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_empty: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_saturation();
        // Preload the statistic just below its ceiling instead of 65k real misses
        force dut.r_mispredict_cnt = 16'hFFF0;
        m_cnt = 16'hFFF0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        release dut.r_mispredict_cnt;
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_preload: got %h expected %h", obs, exp_v); end
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 32'h300, 0, 2'b11, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0, 1, 1, 32'h700 + 32'(i));
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                exp_v = sb.pop_front();
            end
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL sat_%0d: got %h expected %h", i, obs, exp_v); end
        end
        checks++;
        if (mispredict_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff", mispredict_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_state = '0;
        pred_target = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        m_flush = 1'b0; m_idx = '0; m_st = '0; m_redir = '0; m_cnt = '0;
        #1;
        test_reset();
        test_correct();
        test_dir_mispredict();
        test_target_mispredict();
        test_full_wrap();
        test_empty();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
